// File: rtl/par_to_ser_pkg.sv
// Shared types and sizing helpers for the par_to_ser transmitter.
// PAR_TO_SER_PARITY_EN appends an even-parity bit after the data bits.
package par_to_ser_pkg;

  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits on the wire per frame: data plus the optional parity bit.
  function automatic int num_bits(input int n);
`ifdef PAR_TO_SER_PARITY_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(num_bits(n) + 1);
  endfunction

endpackage

// File: rtl/par_to_ser_if.sv
// Load handshake and serial-line bundle between par_to_ser and its user.
interface par_to_ser_if #(
  parameter int N = 8
);
  logic         load;
  logic [N-1:0] parIn;
  logic         ready;
  logic         serial;
  logic         enable;
  logic         clear;
  logic         done;

  modport master (
    output load, parIn,
    input  ready, serial, enable, clear, done
  );

  modport slave (
    input  load, parIn,
    output ready, serial, enable, clear, done
  );
endinterface

// File: rtl/tx_bit_counter.sv
// Bit counter for the transmitter; flags the last bit of the frame.
module tx_bit_counter #(
  parameter int W    = 4,
  parameter int LAST = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(LAST));

endmodule

// File: rtl/par_to_ser.sv
// Parallel-to-serial transmitter: LSB-first bits with enable/clear/done framing.
// PAR_TO_SER_PARITY_EN adds an even-parity bit after the N data bits.
//
// state | meaning
// IDLE  | ready for a load, line held low
// START | one-cycle clear pulse to the receiver
// SHIFT | one bit per en tick, enable follows en
// DONE  | one-cycle done pulse, line low
module par_to_ser
  import par_to_ser_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic MHz10,
  input  logic rst,
  input  logic en,
  input  logic abort,
  par_to_ser_if.slave bus
);

  localparam int NB = num_bits(N);
  localparam int CW = cnt_width(N);

  state_e          state_q, state_d;
  logic [NB-1:0]   shreg_q, shreg_d;
  logic            serial_q, serial_d;
  logic            ready_q, ready_d;
  logic            clear_q, clear_d;
  logic            done_q, done_d;
  logic            cnt_clr, cnt_inc, cnt_tc;

  tx_bit_counter #(
    .W    (CW),
    .LAST (NB - 1)
  ) u_cnt (
    .clk_i   (MHz10),
    .rst_i   (rst),
    .clear_i (cnt_clr),
    .inc_i   (cnt_inc),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    clear_d  = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      shreg_d  = '0;
      cnt_clr  = 1'b1;
      serial_d = 1'b0;
      ready_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ready_d  = 1'b1;
          serial_d = 1'b0;
          if (bus.load) begin
`ifdef PAR_TO_SER_PARITY_EN
            shreg_d = {^bus.parIn, bus.parIn};
`else
            shreg_d = bus.parIn;
`endif
            cnt_clr = 1'b1;
            state_d = START;
            ready_d = 1'b0;
            clear_d = 1'b1;
          end
        end
        START: begin
          state_d  = SHIFT;
          serial_d = shreg_q[0];
          ready_d  = 1'b0;
        end
        SHIFT: begin
          ready_d = 1'b0;
          if (en) begin
            shreg_d = shreg_q >> 1;
            cnt_inc = 1'b1;
            // serial_q presents the next bit for the whole following cycle
            if (cnt_tc) begin
              state_d  = DONE;
              done_d   = 1'b1;
              serial_d = 1'b0;
            end else begin
              serial_d = shreg_q[1];
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge MHz10) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      serial_q <= 1'b0;
      ready_q  <= 1'b1;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      clear_q  <= clear_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.serial = serial_q;
  assign bus.clear  = clear_q;
  assign bus.done   = done_q;
  assign bus.enable = (state_q == SHIFT) & en & ~abort & ~rst;

endmodule

// File: tb/tb_par_to_ser.sv
// Scoreboard bench for par_to_ser: a receiver model rebuilds each frame and is checked on done.
module tb_par_to_ser;

  localparam int N = 8;
`ifdef PAR_TO_SER_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic MHz10 = 1'b0;
  logic rst   = 1'b1;
  logic en    = 1'b0;
  logic abort = 1'b0;

  par_to_ser_if #(.N(N)) bus ();

  par_to_ser #(.N(N)) dut (
    .MHz10 (MHz10),
    .rst   (rst),
    .en    (en),
    .abort (abort),
    .bus   (bus)
  );

  always #5 MHz10 = ~MHz10;

  typedef struct {
    logic [NB-1:0] bits;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge MHz10);
    #1;
  endtask

  task automatic monitor();
    logic [NB-1:0] rx = '0;
    int   nbits = 0;
    int   phase = 0;
    logic prev_en = 1'b0;
    logic prev_serial = 1'b0;
    exp_t e;
    forever begin
      @(negedge MHz10);
      if (bus.clear) begin
        rx = '0;
        nbits = 0;
        phase = 1;
      end else if (bus.ready || bus.done) begin
        phase = 0;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && !prev_en) begin
        check("serial_hold", 32'(bus.serial), 32'(prev_serial));
      end
      if (bus.enable) begin
        check("enable_needs_en", 32'(en), 32'd1);
        rx = {bus.serial, rx[NB-1:1]};
        nbits++;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", 32'(rx), 32'(e.bits));
          check("rx_bit_count", 32'(nbits), 32'(NB));
        end
      end
      prev_en = bus.enable;
      prev_serial = bus.serial;
    end
  endtask

  // period: en asserted every period-th cycle; *_at: loop cycle to act on (0 = never)
  task automatic run_frame(input logic [7:0] word, input logic par, input int period,
                           input bit expect_done, input int load2_at,
                           input int abort_at, input int rst_at);
    exp_t e;
    int c;
    bit got_ready;
    got_ready = 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
    e.bits = {par, word};
`else
    e.bits = word;
`endif
    if (expect_done) exp_q.push_back(e);
    bus.load  = 1'b1;
    bus.parIn = word;
    en = (period == 1);
    tick();
    bus.load = 1'b0;
    for (c = 1; c < 300; c++) begin
      en        = (period == 1) ? 1'b1 : (c % period == 0);
      bus.load  = (c == load2_at);
      if (c == load2_at) bus.parIn = 8'hFF;
      abort     = (c == abort_at);
      rst       = (c == rst_at);
      if (c == abort_at && c != rst_at) begin
        #1;
        check("enable_off_in_abort", 32'(bus.enable), 32'd0);
      end
      tick();
      if (c == abort_at || c == rst_at) begin
        check("stop_ready", 32'(bus.ready), 32'd1);
        check("stop_serial", 32'(bus.serial), 32'd0);
        check("stop_done", 32'(bus.done), 32'd0);
        check("stop_clear", 32'(bus.clear), 32'd0);
        check("stop_enable", 32'(bus.enable), 32'd0);
      end
      if (c > 2 && bus.ready) begin
        got_ready = 1'b1;
        break;
      end
    end
    en = 1'b0; abort = 1'b0; rst = 1'b0; bus.load = 1'b0;
    check("frame_ends", 32'(got_ready), 32'd1);
    tick();
  endtask

  task automatic stimulus();
    bus.load  = 1'b0;
    bus.parIn = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_serial", 32'(bus.serial), 32'd0);
    check("rst_clear", 32'(bus.clear), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_enable", 32'(bus.enable), 32'd0);
    rst = 1'b0;
    tick();

    run_frame(8'hA5, 1'b0, 1, 1'b1, 0, 0, 0);
    run_frame(8'h3C, 1'b0, 4, 1'b1, 0, 0, 0);
    run_frame(8'h01, 1'b1, 1, 1'b1, 4, 0, 0);
    run_frame(8'hFF, 1'b0, 1, 1'b1, 0, 0, 0);
    run_frame(8'h96, 1'b0, 1, 1'b0, 0, 5, 0);
    run_frame(8'h5A, 1'b0, 1, 1'b1, 0, 0, 0);
    run_frame(8'hC3, 1'b0, 1, 1'b0, 0, 0, 7);
    run_frame(8'hC3, 1'b0, 1, 1'b0, 0, 7, 7);
    run_frame(8'h81, 1'b0, 3, 1'b1, 0, 0, 0);

    // load and abort together in IDLE: nothing is latched
    bus.load = 1'b1; bus.parIn = 8'h77; abort = 1'b1;
    tick();
    bus.load = 1'b0; abort = 1'b0;
    check("ld_abort_ready", 32'(bus.ready), 32'd1);
    check("ld_abort_clear", 32'(bus.clear), 32'd0);
    tick();
    check("ld_abort_idle", 32'(bus.clear), 32'd0);

`ifdef PAR_TO_SER_PARITY_EN
    run_frame(8'h07, 1'b1, 1, 1'b1, 0, 0, 0);
    run_frame(8'h03, 1'b0, 1, 1'b1, 0, 0, 0);
`endif

    repeat (5) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
  end

endmodule
